// File: rtl/burst_ram_arbiter_pkg.sv
// burst_ram_arbiter_pkg: shared constants and helpers for the BurstRAM arbiter
package burst_ram_arbiter_pkg;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    function automatic int cnt_width(input int burst_count);
        return $clog2(burst_count + 1);
    endfunction
endpackage

// File: rtl/burst_ram_arbiter_rr2.sv
// arbiter_rr2: two-way round-robin pick; a tie goes to the port that was not granted last
module arbiter_rr2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant_valid,
    output logic grant_ix
);
    // sole requester wins outright, otherwise alternate away from last
    always_comb begin
        grant_valid = req0 | req1;
        grant_ix    = (req0 & req1) ? ~last : req1;
    end
endmodule

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: shares one BurstRAM between two burst masters, grant held per burst
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT    = 4
) (
    input  logic                      clk,
    input  logic                      sys_rst_n,
    input  logic                      m0_cmd,
    input  logic                      m0_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] m0_addr,
    input  logic [DATA_W-1:0]         m0_wr_data,
    input  logic [MASK_W-1:0]         m0_data_mask,
    output logic [DATA_W-1:0]         m0_rd_data,
    output logic                      m0_rd_data_valid,
    output logic                      m0_busy,
    input  logic                      m1_cmd,
    input  logic                      m1_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] m1_addr,
    input  logic [DATA_W-1:0]         m1_wr_data,
    input  logic [MASK_W-1:0]         m1_data_mask,
    output logic [DATA_W-1:0]         m1_rd_data,
    output logic                      m1_rd_data_valid,
    output logic                      m1_busy,
    output logic                      br_cmd,
    output logic                      br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0] br_addr,
    output logic [DATA_W-1:0]         br_wr_data,
    output logic [MASK_W-1:0]         br_data_mask,
    input  logic [DATA_W-1:0]         br_rd_data,
    input  logic                      br_rd_data_valid,
    input  logic                      br_busy
);
    localparam int CW = cnt_width(BURST_COUNT);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_COUNT - 1);

    logic [1:0]    state;
    logic          owner;
    logic          last;
    logic [CW-1:0] cnt;
    logic          grant_valid;
    logic          grant_ix;
    logic          accept;
    logic          sel;

    arbiter_rr2 u_rr (
        .req0        (m0_cmd_en),
        .req1        (m1_cmd_en),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_ix    (grant_ix)
    );

    // same-cycle acceptance from IDLE; outside IDLE the owner steers the data path
    always_comb begin
        accept           = sys_rst_n && state == IDLE && !br_busy && grant_valid;
        sel              = (state == IDLE) ? grant_ix : owner;
        br_cmd_en        = accept;
        br_cmd           = sel ? m1_cmd : m0_cmd;
        br_addr          = sel ? m1_addr : m0_addr;
        br_wr_data       = sel ? m1_wr_data : m0_wr_data;
        br_data_mask     = sel ? m1_data_mask : m0_data_mask;
        m0_busy          = !(accept && !grant_ix);
        m1_busy          = !(accept && grant_ix);
        m0_rd_data       = br_rd_data;
        m1_rd_data       = br_rd_data;
        m0_rd_data_valid = state == READ && br_rd_data_valid && !owner;
        m1_rd_data_valid = state == READ && br_rd_data_valid && owner;
    end

    // burst tracking: latch winner on accept, count beats until the burst is complete
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else if (accept) begin
            owner <= grant_ix;
            last  <= grant_ix;
            state <= !br_cmd ? READ : (BURST_COUNT > 1) ? WRITE : IDLE;
            cnt   <= br_cmd ? CW'(1) : '0;
        end else if ((state == READ && br_rd_data_valid) || state == WRITE) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter: randomized scoreboard bench with a BurstRAM model and a rule-level arbitration model
module tb_burst_ram_arbiter;
    import burst_ram_arbiter_pkg::*;
    localparam int AW = 4;
    localparam int BC = 4;

    logic          clk = 0;
    logic          sys_rst_n = 0;
    logic [1:0]    cmd = 0;
    logic [1:0]    cmd_en = 0;
    logic [AW-1:0] addr [2];
    logic [63:0]   wd [2];
    logic [7:0]    mk [2];
    logic [63:0]   rdd0, rdd1;
    logic [1:0]    rdv, busy;
    logic          br_cmd, br_cmd_en;
    logic [AW-1:0] br_addr;
    logic [63:0]   br_wr_data;
    logic [7:0]    br_data_mask;
    logic [63:0]   br_rd_data = 0;
    logic          br_rd_data_valid = 0;
    logic          br_busy = 1;

    int vectors = 0;
    int miscompares = 0;

    burst_ram_arbiter #(.DEPTH_BITWIDTH(AW), .BURST_COUNT(BC)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .m0_cmd(cmd[0]), .m0_cmd_en(cmd_en[0]), .m0_addr(addr[0]), .m0_wr_data(wd[0]),
        .m0_data_mask(mk[0]), .m0_rd_data(rdd0), .m0_rd_data_valid(rdv[0]), .m0_busy(busy[0]),
        .m1_cmd(cmd[1]), .m1_cmd_en(cmd_en[1]), .m1_addr(addr[1]), .m1_wr_data(wd[1]),
        .m1_data_mask(mk[1]), .m1_rd_data(rdd1), .m1_rd_data_valid(rdv[1]), .m1_busy(busy[1]),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_busy(br_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] seed(input int i);
        return {32'hC0DE_0000 + 32'(i), ~(32'(i) * 32'h9E37_79B9)};
    endfunction

    // BurstRAM model: latches commands, streams write beats in, returns read beats with random gaps
    logic [63:0]   ram [16];
    logic [AW-1:0] rptr, wptr;
    int            rleft, wleft;
    always @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rleft <= 0;
            wleft <= 0;
            br_rd_data_valid <= 0;
            for (int i = 0; i < 16; i++) ram[i] <= seed(i);
        end else begin
            br_rd_data_valid <= 0;
            if (br_cmd_en && !br_busy) begin
                if (br_cmd) begin
                    ram[br_addr] <= br_wr_data;
                    wptr <= br_addr + 1'b1;
                    wleft <= BC - 1;
                end else begin
                    rptr <= br_addr;
                    rleft <= BC;
                end
            end else if (wleft > 0) begin
                ram[wptr] <= br_wr_data;
                wptr <= wptr + 1'b1;
                wleft <= wleft - 1;
            end
            if (rleft > 0 && $urandom_range(0, 3) != 0) begin
                br_rd_data <= ram[rptr];
                br_rd_data_valid <= 1;
                rptr <= rptr + 1'b1;
                rleft <= rleft - 1;
            end
        end
    end

    // reference model state: memory image, pending expectations and grant history
    logic [63:0]   ref_mem [16];
    logic [63:0]   rd_exp [$];
    logic [63:0]   wr_q0 [$];
    logic [63:0]   wr_q1 [$];
    int            grants [$];
    int            rd_left = 0, wr_left = 0;
    logic          rd_own = 0, wr_own = 0, last_m = 1;
    logic [AW-1:0] wr_ptr = 0, a;
    logic          idle, exp_en, w;
    logic [63:0]   beat;

    // monitor: predicts grant/busy/data from the arbitration rules and checks every cycle
    always @(negedge clk) begin
        if (!sys_rst_n) begin
            chk("rst_busy", 64'(busy), 64'h3);
            chk("rst_cmd_en", 64'(br_cmd_en), 64'h0);
            chk("rst_rd_valid", 64'(rdv), 64'h0);
            last_m = 1;
            rd_left = 0;
            wr_left = 0;
            rd_exp.delete();
            wr_q0.delete();
            wr_q1.delete();
            for (int i = 0; i < 16; i++) ref_mem[i] = seed(i);
        end else begin
            idle = rd_left == 0 && wr_left == 0;
            exp_en = idle && !br_busy && cmd_en != 2'b00;
            w = (cmd_en == 2'b11) ? !last_m : cmd_en[1];
            chk("cmd_en", 64'(br_cmd_en), 64'(exp_en));
            chk("busy", 64'(busy), 64'({!(exp_en && w), !(exp_en && !w)}));
            if (br_rd_data_valid && rd_left > 0) begin
                chk("rd_valid", 64'(rdv), rd_own ? 64'h2 : 64'h1);
                chk("rd_data", rd_own ? rdd1 : rdd0, rd_exp.pop_front());
                rd_left--;
            end else
                chk("rd_valid_quiet", 64'(rdv), 64'h0);
            if (wr_left > 0) begin
                beat = wr_own ? wr_q1.pop_front() : wr_q0.pop_front();
                chk("wr_data", br_wr_data, beat);
                chk("wr_mask", 64'(br_data_mask), 64'(mk[wr_own]));
                ref_mem[wr_ptr] = beat;
                wr_ptr++;
                wr_left--;
            end
            if (exp_en) begin
                chk("br_addr", 64'(br_addr), 64'(addr[w]));
                chk("br_cmd", 64'(br_cmd), 64'(cmd[w]));
                grants.push_back(int'(w));
                last_m = w;
                if (cmd[w]) begin
                    beat = w ? wr_q1.pop_front() : wr_q0.pop_front();
                    chk("wr_data0", br_wr_data, beat);
                    chk("wr_mask0", 64'(br_data_mask), 64'(mk[w]));
                    ref_mem[addr[w]] = beat;
                    wr_ptr = addr[w] + 1'b1;
                    wr_own = w;
                    wr_left = BC - 1;
                end else begin
                    for (int i = 0; i < BC; i++) begin
                        a = addr[w] + AW'(i);
                        rd_exp.push_back(ref_mem[a]);
                    end
                    rd_own = w;
                    rd_left = BC;
                end
            end else if (idle && cmd_en == 2'b00)
                chk("mirror_addr", 64'(br_addr), 64'(addr[0]));
        end
    end

    int rv0 = 0, rv1 = 0;
    // per-master valid beat tally
    always @(negedge clk) begin
        if (rdv[0]) rv0++;
        if (rdv[1]) rv1++;
    end

    task automatic issue(input int p, input logic c, input logic [AW-1:0] ad,
                         input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3);
        logic [63:0] d [4];
        int n;
        n = 0;
        d[0] = b0; d[1] = b1; d[2] = b2; d[3] = b3;
        if (c) for (int i = 0; i < BC; i++) if (p == 1) wr_q1.push_back(d[i]); else wr_q0.push_back(d[i]);
        cmd[p] = c;
        addr[p] = ad;
        wd[p] = d[0];
        mk[p] = 8'($urandom);
        cmd_en[p] = 1;
        do begin @(negedge clk); n++; end while (busy[p] && n < 400);
        chk("accept_timeout", 64'(busy[p]), 64'h0);
        if (busy[p]) begin
            cmd_en[p] = 0;
            if (p == 1) wr_q1.delete(); else wr_q0.delete();
            return;
        end
        @(posedge clk); #1;
        cmd_en[p] = 0;
        if (c) for (int i = 1; i < BC; i++) begin
            wd[p] = d[i];
            @(posedge clk); #1;
        end
    endtask

    task automatic rand_issue(input int p);
        issue(p, 1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rd_left != 0 || wr_left != 0) && n < 400) begin @(negedge clk); n++; end
        chk("idle_timeout", 64'(rd_left + wr_left), 64'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n, s0, s1;
        logic done;
        addr[0] = 0; addr[1] = 0; wd[0] = 0; wd[1] = 0; mk[0] = 0; mk[1] = 0;
        repeat (3) @(posedge clk);
        #1 sys_rst_n = 1;
        // both request while the RAM is still busy; port 0 must win the first tie
        fork
            issue(0, 0, 4'd1, 0, 0, 0, 0);
            issue(1, 0, 4'd3, 0, 0, 0, 0);
            begin repeat (4) @(posedge clk); #1 br_busy = 0; end
        join
        wait_idle();
        chk("post_reset_grants", 64'(grants.size()), 64'd2);
        if (grants.size() == 2) begin
            chk("post_reset_first", 64'(grants[0]), 64'd0);
            chk("post_reset_second", 64'(grants[1]), 64'd1);
        end
        // round-robin fairness under continuous contention
        grants.delete();
        fork
            for (int k = 0; k < 3; k++) issue(0, 0, AW'($urandom), 0, 0, 0, 0);
            for (int k = 0; k < 3; k++) issue(1, 0, AW'($urandom), 0, 0, 0, 0);
        join
        wait_idle();
        for (int k = 0; k < 6; k++) chk("rr_order", k < grants.size() ? 64'(grants[k]) : 64'd9, 64'(k % 2));
        // single read of addr 2 delivers exactly BC beats to m0 only
        s0 = rv0; s1 = rv1;
        issue(0, 0, 4'd2, 0, 0, 0, 0);
        wait_idle();
        chk("single_rd_beats_m0", 64'(rv0 - s0), 64'(BC));
        chk("single_rd_beats_m1", 64'(rv1 - s1), 64'd0);
        // write burst from m1 then read back on m0
        issue(1, 1, 4'd4, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}});
        wait_idle();
        chk("ram_w0", ram[4], {16{4'h1}});
        chk("ram_w1", ram[5], {16{4'h2}});
        chk("ram_w2", ram[6], {16{4'h3}});
        chk("ram_w3", ram[7], {16{4'h4}});
        s0 = rv0; s1 = rv1;
        issue(0, 0, 4'd4, 0, 0, 0, 0);
        wait_idle();
        chk("readback_beats_m0", 64'(rv0 - s0), 64'(BC));
        chk("readback_beats_m1", 64'(rv1 - s1), 64'd0);
        // randomized traffic with random RAM busy
        done = 0;
        fork
            begin
                fork
                    for (int k = 0; k < 12; k++) begin repeat ($urandom_range(1, 4)) @(posedge clk); #1; rand_issue(0); end
                    for (int k = 0; k < 12; k++) begin repeat ($urandom_range(1, 4)) @(posedge clk); #1; rand_issue(1); end
                join
                done = 1;
            end
            begin
                while (!done) begin @(posedge clk); #1 br_busy = ($urandom_range(0, 5) == 0); end
                br_busy = 0;
            end
        join
        wait_idle();
        // asynchronous reset in the middle of a write burst
        for (int i = 0; i < BC; i++) wr_q0.push_back({$urandom, $urandom});
        cmd[0] = 1; addr[0] = 4'd8; wd[0] = wr_q0[0]; cmd_en[0] = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (busy[0] && n < 100);
        chk("mw_accept", 64'(busy[0]), 64'h0);
        @(posedge clk); #1 cmd_en[0] = 0; wd[0] = wr_q0[0];
        @(posedge clk); #1 wd[0] = wr_q0[0];
        @(posedge clk); #2 sys_rst_n = 0;
        #1;
        chk("mw_rst_busy", 64'(busy), 64'h3);
        chk("mw_rst_cmd_en", 64'(br_cmd_en), 64'h0);
        repeat (2) @(posedge clk);
        #1 sys_rst_n = 1;
        grants.delete();
        fork
            issue(0, 0, 4'd5, 0, 0, 0, 0);
            issue(1, 0, 4'd9, 0, 0, 0, 0);
        join
        wait_idle();
        chk("mw_tie_first", grants.size() > 0 ? 64'(grants[0]) : 64'd9, 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
        $fatal(1);
    end
endmodule
